// File: rtl/apb_ctrl_pkg.sv
// Shared types and default widths for the AHB-to-APB controller.
// Optional APB_CTRL_PREADY_EN adds pready wait states to the ENABLE phase.
package apb_ctrl_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int SEL_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_READ    = 3'd2,
        ST_RENABLE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_WENABLE = 3'd5
    } state_e;

    function automatic logic is_enable(state_e s);
        return (s == ST_RENABLE) || (s == ST_WENABLE);
    endfunction

endpackage

// File: rtl/apb_ctrl_fsm.sv
// Next-state logic for the AHB-to-APB controller.
// Optional APB_CTRL_PREADY_EN: pready stretches the ENABLE states.
module apb_ctrl_fsm
    import apb_ctrl_pkg::*;
(
    input  state_e state_q,
    input  logic   req,
    input  logic   hwrite,
    input  logic   pready,
    output state_e state_d,
    output logic   accept,
    output logic   en_done
);

    always_comb begin
        en_done = is_enable(state_q) && pready;
        // An ENABLE state takes a new request on its completing edge,
        // the same edge that raises hreadyout, so no IDLE gap appears.
        accept  = req && ((state_q == ST_IDLE) || en_done);
        state_d = state_q;
        unique case (state_q)
            ST_READ:  state_d = ST_RENABLE;
            ST_WWAIT: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_WENABLE;
            ST_RENABLE,
            ST_WENABLE: begin
                if (en_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = hwrite ? ST_WWAIT : ST_READ;
        end
    end

endmodule

// File: rtl/apb_controller.sv
// AHB-to-APB transfer controller with fully registered outputs.
// Define APB_CTRL_PREADY_EN to add the pready input and wait states.
module apb_controller
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [SEL_W-1:0]  tempselx,
    input  logic [DATA_W-1:0] pr_data,
`ifdef APB_CTRL_PREADY_EN
    input  logic              pready,
`endif
    output logic              pwrite,
    output logic [SEL_W-1:0]  psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata
);

    state_e state_q, state_d;
    logic   accept, en_done, pready_w;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              hreadyout_q, hreadyout_d;

`ifdef APB_CTRL_PREADY_EN
    assign pready_w = pready;
`else
    assign pready_w = 1'b1;
`endif

    apb_ctrl_fsm u_fsm (
        .state_q (state_q),
        .req     (valid && (tempselx != '0)),
        .hwrite  (hwrite),
        .pready  (pready_w),
        .state_d (state_d),
        .accept  (accept),
        .en_done (en_done)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        addr_d      = accept ? haddr : addr_q;
        wr_d        = accept ? hwrite : wr_q;
        sel_d       = accept ? tempselx : sel_q;
        psel_d      = '0;
        if (state_d inside {ST_READ, ST_RENABLE, ST_WRITE, ST_WENABLE}) begin
            psel_d = sel_d;
        end
        penable_d   = is_enable(state_d);
        pwrite_d    = wr_d &&
                      ((state_d == ST_WRITE) || (state_d == ST_WENABLE));
        pwdata_d    = (state_q == ST_WWAIT) ? hwdata : pwdata_q;
        hrdata_d    = ((state_q == ST_RENABLE) && en_done) ? pr_data
                                                           : hrdata_q;
        hreadyout_d = (state_d == ST_IDLE) || en_done;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q      <= '0;
            wr_q        <= 1'b0;
            sel_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            sel_q       <= sel_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = addr_q;
    assign pwdata    = pwdata_q;
    assign hreadyout = hreadyout_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_apb_controller.sv
// Directed, table-driven bench for apb_controller.
// Define APB_CTRL_PREADY_EN to also exercise pready wait states.
module tb_apb_controller;

    logic        hclk;
    logic        hresetn;
    logic        valid;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  tempselx;
    logic [31:0] pr_data;
    logic        pready;
    logic        pwrite;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;
    logic [31:0] hrdata;

    int checks = 0;
    int errors = 0;

    apb_controller dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .valid     (valid),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .tempselx  (tempselx),
        .pr_data   (pr_data),
`ifdef APB_CTRL_PREADY_EN
        .pready    (pready),
`endif
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .hreadyout (hreadyout),
        .hrdata    (hrdata)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    typedef struct {
        logic        valid;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [2:0]  sel;
        logic [31:0] prd;
        logic [2:0]  e_psel;
        logic        e_pen;
        logic        e_pwr;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic        e_rdy;
        logic [31:0] e_hrdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic v, logic w, logic [31:0] a, logic [31:0] d,
        logic [2:0] s, logic [31:0] p,
        logic [2:0] eps, logic epe, logic epw, logic [31:0] epa,
        logic [31:0] epd, logic erd, logic [31:0] ehr);
        vec_t r;
        r.valid = v;   r.hwrite = w;   r.haddr = a;
        r.hwdata = d;  r.sel = s;      r.prd = p;
        r.e_psel = eps; r.e_pen = epe; r.e_pwr = epw;
        r.e_paddr = epa; r.e_pwdata = epd;
        r.e_rdy = erd; r.e_hrdata = ehr;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, " psel"}, 32'(psel), 32'h0);
        chk({tag, " penable"}, 32'(penable), 32'h0);
        chk({tag, " pwrite"}, 32'(pwrite), 32'h0);
        chk({tag, " paddr"}, paddr, 32'h0);
        chk({tag, " pwdata"}, pwdata, 32'h0);
        chk({tag, " hrdata"}, hrdata, 32'h0);
        chk({tag, " hreadyout"}, 32'(hreadyout), 32'h1);
    endtask

    task automatic drive(logic v, logic w, logic [31:0] a,
                         logic [31:0] d, logic [2:0] s,
                         logic [31:0] p);
        valid = v; hwrite = w; haddr = a;
        hwdata = d; tempselx = s; pr_data = p;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hresetn = 1'b0;
        pready  = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0);

        // read
        vecs.push_back(mk(1,0,32'h8000_0010,0,3'b001,0,
            3'b001,0,0,32'h8000_0010,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,32'hAAAA_0000,
            3'b001,1,0,32'h8000_0010,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,32'h1234_5678,
            3'b000,0,0,32'h8000_0010,0,1,32'h1234_5678));
        vecs.push_back(mk(0,0,0,0,0,0,
            3'b000,0,0,32'h8000_0010,0,1,32'h1234_5678));
        // write, with requests offered while hreadyout=0
        vecs.push_back(mk(1,1,32'h8000_0020,32'h1111_1111,3'b010,0,
            3'b000,0,0,32'h8000_0020,0,0,32'h1234_5678));
        vecs.push_back(mk(1,0,32'h9000_0000,32'hDEAD_BEEF,3'b100,0,
            3'b010,0,1,32'h8000_0020,32'hDEAD_BEEF,0,32'h1234_5678));
        vecs.push_back(mk(1,0,32'h9000_0000,0,3'b100,0,
            3'b010,1,1,32'h8000_0020,32'hDEAD_BEEF,0,32'h1234_5678));
        vecs.push_back(mk(0,0,0,0,0,0,
            3'b000,0,0,32'h8000_0020,32'hDEAD_BEEF,1,32'h1234_5678));
        // no select
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1,logic'(i%2),32'h1234_5678,0,3'b000,0,
                3'b000,0,0,32'h8000_0020,32'hDEAD_BEEF,1,
                32'h1234_5678));
        end
        // back-to-back read, write, read, read
        vecs.push_back(mk(1,0,32'hA000_0000,0,3'b001,0,
            3'b001,0,0,32'hA000_0000,32'hDEAD_BEEF,0,32'h1234_5678));
        vecs.push_back(mk(1,0,32'hA000_0000,0,3'b001,0,
            3'b001,1,0,32'hA000_0000,32'hDEAD_BEEF,0,32'h1234_5678));
        vecs.push_back(mk(1,1,32'hA000_0004,0,3'b001,32'hCAFE_0001,
            3'b000,0,0,32'hA000_0004,32'hDEAD_BEEF,1,32'hCAFE_0001));
        vecs.push_back(mk(1,0,32'hA000_0008,32'h5555_AAAA,3'b001,0,
            3'b001,0,1,32'hA000_0004,32'h5555_AAAA,0,32'hCAFE_0001));
        vecs.push_back(mk(1,0,32'hA000_0008,0,3'b001,0,
            3'b001,1,1,32'hA000_0004,32'h5555_AAAA,0,32'hCAFE_0001));
        vecs.push_back(mk(1,0,32'hA000_0008,0,3'b001,0,
            3'b001,0,0,32'hA000_0008,32'h5555_AAAA,1,32'hCAFE_0001));
        vecs.push_back(mk(0,0,0,0,0,32'h0BAD_F00D,
            3'b001,1,0,32'hA000_0008,32'h5555_AAAA,0,32'hCAFE_0001));
        vecs.push_back(mk(1,0,32'hB000_0000,0,3'b001,32'h600D_F00D,
            3'b001,0,0,32'hB000_0000,32'h5555_AAAA,1,32'h600D_F00D));
        vecs.push_back(mk(0,0,0,0,0,0,
            3'b001,1,0,32'hB000_0000,32'h5555_AAAA,0,32'h600D_F00D));
        vecs.push_back(mk(0,0,0,0,0,32'h7777_8888,
            3'b000,0,0,32'hB000_0000,32'h5555_AAAA,1,32'h7777_8888));

        #12;
        chk_reset_vals("reset");
        hresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].hwrite, vecs[i].haddr,
                  vecs[i].hwdata, vecs[i].sel, vecs[i].prd);
            step();
            chk($sformatf("row%0d psel", i), 32'(psel),
                32'(vecs[i].e_psel));
            chk($sformatf("row%0d penable", i), 32'(penable),
                32'(vecs[i].e_pen));
            chk($sformatf("row%0d pwrite", i), 32'(pwrite),
                32'(vecs[i].e_pwr));
            chk($sformatf("row%0d paddr", i), paddr, vecs[i].e_paddr);
            chk($sformatf("row%0d pwdata", i), pwdata,
                vecs[i].e_pwdata);
            chk($sformatf("row%0d hreadyout", i), 32'(hreadyout),
                32'(vecs[i].e_rdy));
            chk($sformatf("row%0d hrdata", i), hrdata,
                vecs[i].e_hrdata);
        end

        // reset asserted mid-WENABLE, away from any clock edge
        drive(1'b1, 1'b1, 32'h8000_0040, 32'h0, 3'b100, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0F0F_0F0F, 3'b000, 32'h0);
        step();
        step();
        chk("wen penable", 32'(penable), 32'h1);
        chk("wen pwdata", pwdata, 32'h0F0F_0F0F);
        #2;
        hresetn = 1'b0;
        #1;
        chk_reset_vals("async");
        step();
        chk_reset_vals("held");
        #2;
        hresetn = 1'b1;
        drive(1'b1, 1'b0, 32'h8000_0050, 32'h0, 3'b001, 32'h0);
        step();
        chk("rst rd psel", 32'(psel), 32'h1);
        chk("rst rd paddr", paddr, 32'h8000_0050);
        chk("rst rd rdy", 32'(hreadyout), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0);
        step();
        chk("rst rd penable", 32'(penable), 32'h1);
        pr_data = 32'h1357_2468;
        step();
        chk("rst rd hrdata", hrdata, 32'h1357_2468);
        chk("rst rd done", 32'(hreadyout), 32'h1);
        chk("rst rd psel0", 32'(psel), 32'h0);

`ifdef APB_CTRL_PREADY_EN
        drive(1'b1, 1'b0, 32'h8000_0060, 32'h0, 3'b100, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'hBAD0_BAD0);
        pready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("wait%0d penable", i), 32'(penable), 32'h1);
            chk($sformatf("wait%0d rdy", i), 32'(hreadyout), 32'h0);
            chk($sformatf("wait%0d psel", i), 32'(psel), 32'h4);
            chk($sformatf("wait%0d hrdata", i), hrdata,
                32'h1357_2468);
        end
        pready  = 1'b1;
        pr_data = 32'h2468_ACE0;
        step();
        chk("pready hrdata", hrdata, 32'h2468_ACE0);
        chk("pready rdy", 32'(hreadyout), 32'h1);
        chk("pready penable", 32'(penable), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
